// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: IFU and LSU request/response channels plus the shared memory port.
// The arbiter takes the master view; the clients and the memory model sit on the slave side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_addr;
  logic                  ifu_resp_valid;
  logic [DATA_WIDTH-1:0] ifu_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic                  lsu_wen;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic [3:0]            lsu_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_WIDTH-1:0] lsu_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin on conflicts; otherwise the LSU always wins.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus,
  output logic              err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam int              CNT_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  logic [1:0]            state_q,    state_d;
  logic                  ownerLsu_q, ownerLsu_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic                  wen_q,      wen_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [3:0]            wmask_q,    wmask_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic                  err_q,      err_d;

  logic                  idleActive;
  logic                  busy;
  logic                  grantLsu;
  logic                  grantIfu;
  logic                  respHit;
  logic                  timeoutHit;
  logic                  respFire;
  logic [DATA_WIDTH-1:0] respData;

  // Reset masks every handshake so a transaction cut short by rst can never answer.
  assign idleActive = (state_q == S_IDLE) && !rst;
  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);

`ifdef MEM_ARB_RR_EN
  logic favourLsu_q, favourLsu_d;

  assign grantLsu = idleActive && bus.lsu_req_valid && (!bus.ifu_req_valid || favourLsu_q);

  always_comb begin
    favourLsu_d = favourLsu_q;
    if (grantLsu) begin
      favourLsu_d = 1'b0;
    end else if (grantIfu) begin
      favourLsu_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      favourLsu_q <= 1'b1;
    end else begin
      favourLsu_q <= favourLsu_d;
    end
  end
`else
  assign grantLsu = idleActive && bus.lsu_req_valid;
`endif

  assign grantIfu = idleActive && bus.ifu_req_valid && !grantLsu;

  assign respHit    = (state_q == S_WAIT) && bus.mem_resp_valid && !rst;
  assign timeoutHit = (TIMEOUT_CYC != 0) && busy && (cnt_q == CNT_LIMIT) && !respHit && !rst;
  assign respFire   = respHit || timeoutHit;

  // Stores acknowledge with zero data; a watchdog abort returns a recognisable poison word.
  always_comb begin
    respData = bus.mem_rdata;
    if (timeoutHit) begin
      respData = TIMEOUT_DATA;
    end else if (wen_q) begin
      respData = '0;
    end
  end

  assign bus.ifu_req_ready  = grantIfu;
  assign bus.lsu_req_ready  = grantLsu;
  assign bus.ifu_resp_valid = respFire && !ownerLsu_q;
  assign bus.lsu_resp_valid = respFire && ownerLsu_q;
  assign bus.ifu_rdata      = (respFire && !ownerLsu_q) ? respData : '0;
  assign bus.lsu_rdata      = (respFire && ownerLsu_q) ? respData : '0;

  assign bus.mem_req_valid  = (state_q == S_ISSUE) && !rst;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

  assign err_timeout        = err_q;

  always_comb begin
    state_d    = state_q;
    ownerLsu_d = ownerLsu_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (grantLsu) begin
          ownerLsu_d = 1'b1;
          addr_d     = bus.lsu_addr;
          wen_d      = bus.lsu_wen;
          wdata_d    = bus.lsu_wen ? bus.lsu_wdata : '0;
          wmask_d    = bus.lsu_wen ? bus.lsu_wmask : 4'b0000;
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end else if (grantIfu) begin
          ownerLsu_d = 1'b0;
          addr_d     = bus.ifu_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          wmask_d    = 4'b0000;
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (timeoutHit) begin
          state_d = S_IDLE;
        end else if (bus.mem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (respFire) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timeoutHit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ownerLsu_q <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= 4'b0000;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ownerLsu_q <= ownerLsu_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter; the bench plays both clients and the memory.
// Expected grants and responses come from a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic errTimeout;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bus_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_timeout(errTimeout)
  );

  always #5 clk = ~clk;

  // Pending client requests, held until granted.
  bit          ifuPend = 1'b0;
  bit          lsuPend = 1'b0;
  logic [AW-1:0] ifuAddrV  = '0;
  logic [AW-1:0] lsuAddrV  = '0;
  logic          lsuWenV   = 1'b0;
  logic [DW-1:0] lsuWdataV = '0;
  logic [3:0]    lsuWmaskV = '0;

  // Model state: who is favoured on a conflict, whether the sticky error should be up.
  bit rrMode    = 1'b0;
  bit favourLsu = 1'b1;
  bit errExp    = 1'b0;
  bit postNew   = 1'b0;

  // Expected latched transaction.
  bit            ownLsu   = 1'b0;
  logic [AW-1:0] expAddr  = '0;
  bit            expWen   = 1'b0;
  logic [DW-1:0] expWdata = '0;
  logic [3:0]    expWmask = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    bus.ifu_req_valid = ifuPend;
    bus.ifu_addr      = ifuAddrV;
    bus.lsu_req_valid = lsuPend;
    bus.lsu_addr      = lsuAddrV;
    bus.lsu_wen       = lsuWenV;
    bus.lsu_wdata     = lsuWdataV;
    bus.lsu_wmask     = lsuWmaskV;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomRequests(input bit forceOne);
    if (!ifuPend && $urandom_range(0, 2) == 0) begin
      ifuPend  = 1'b1;
      ifuAddrV = $urandom & 32'hFFFF_FFFC;
    end
    if (!lsuPend && $urandom_range(0, 2) == 0) begin
      lsuPend   = 1'b1;
      lsuAddrV  = $urandom;
      lsuWenV   = 1'($urandom_range(0, 1));
      lsuWdataV = $urandom;
      lsuWmaskV = 4'($urandom_range(1, 15));
    end
    if (forceOne && !ifuPend && !lsuPend) begin
      ifuPend  = 1'b1;
      ifuAddrV = $urandom & 32'hFFFF_FFFC;
    end
  endtask

  // Busy-cycle check: nobody is granted or answered; the memory port shows the latched request.
  task automatic checkQuiet(input string ph, input bit memValid);
    checkOutput({ph, ".ifuReady"}, bus.ifu_req_ready, 0);
    checkOutput({ph, ".lsuReady"}, bus.lsu_req_ready, 0);
    checkOutput({ph, ".ifuResp"}, bus.ifu_resp_valid, 0);
    checkOutput({ph, ".lsuResp"}, bus.lsu_resp_valid, 0);
    checkOutput({ph, ".memValid"}, bus.mem_req_valid, memValid);
    checkOutput({ph, ".err"}, errTimeout, errExp);
    if (memValid) begin
      checkOutput({ph, ".memAddr"}, bus.mem_addr, expAddr);
      checkOutput({ph, ".memWen"}, bus.mem_wen, expWen);
      checkOutput({ph, ".memWmask"}, bus.mem_wmask, expWmask);
      if (expWen) checkOutput({ph, ".memWdata"}, bus.mem_wdata, expWdata);
    end
  endtask

  task automatic checkResp(input string ph, input logic [DW-1:0] data, input bit memValid);
    checkOutput({ph, ".ifuResp"}, bus.ifu_resp_valid, !ownLsu);
    checkOutput({ph, ".lsuResp"}, bus.lsu_resp_valid, ownLsu);
    if (ownLsu) checkOutput({ph, ".lsuRdata"}, bus.lsu_rdata, data);
    else        checkOutput({ph, ".ifuRdata"}, bus.ifu_rdata, data);
    checkOutput({ph, ".ifuReady"}, bus.ifu_req_ready, 0);
    checkOutput({ph, ".lsuReady"}, bus.lsu_req_ready, 0);
    checkOutput({ph, ".memValid"}, bus.mem_req_valid, memValid);
    checkOutput({ph, ".err"}, errTimeout, errExp);
  endtask

  task automatic emptyIdle();
    applyStimulus();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'($urandom_range(0, 1));
    #2;
    checkQuiet("idle", 1'b0);
    nextCycle();
  endtask

  task automatic doGrant();
    bit winLsu;
    applyStimulus();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'($urandom_range(0, 1));
    bus.mem_rdata      = $urandom;
    #2;
    if (ifuPend && lsuPend) winLsu = rrMode ? favourLsu : 1'b1;
    else                    winLsu = lsuPend;
    checkOutput("grant.ifuReady", bus.ifu_req_ready, !winLsu);
    checkOutput("grant.lsuReady", bus.lsu_req_ready, winLsu);
    checkOutput("grant.memValid", bus.mem_req_valid, 0);
    checkOutput("grant.ifuResp", bus.ifu_resp_valid, 0);
    checkOutput("grant.lsuResp", bus.lsu_resp_valid, 0);
    checkOutput("grant.err", errTimeout, errExp);
    ownLsu = winLsu;
    if (winLsu) begin
      expAddr  = lsuAddrV;
      expWen   = lsuWenV;
      expWdata = lsuWdataV;
      expWmask = lsuWenV ? lsuWmaskV : 4'b0000;
      lsuPend  = 1'b0;
    end else begin
      expAddr  = ifuAddrV;
      expWen   = 1'b0;
      expWdata = '0;
      expWmask = 4'b0000;
      ifuPend  = 1'b0;
    end
    favourLsu = !winLsu;
    nextCycle();
  endtask

  // One full transaction: grant, rDelay stalled issue cycles, accept, dDelay wait cycles, response.
  // With noResp the memory stays silent and the watchdog must answer on the TMO-th busy cycle.
  task automatic runTxn(input int rDelay, input int dDelay, input bit noResp, input logic [DW-1:0] rdata);
    doGrant();
    if (postNew) randomRequests(1'b0);
    applyStimulus();
    if (!noResp) begin
      for (int i = 0; i < rDelay; i++) begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'($urandom_range(0, 1));
        #2;
        checkQuiet("issue", 1'b1);
        nextCycle();
      end
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'($urandom_range(0, 1));
      #2;
      checkQuiet("accept", 1'b1);
      nextCycle();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      for (int i = 0; i < dDelay; i++) begin
        #2;
        checkQuiet("wait", 1'b0);
        nextCycle();
      end
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = rdata;
      #2;
      checkResp("resp", expWen ? '0 : rdata, 1'b0);
      nextCycle();
      bus.mem_resp_valid = 1'b0;
    end else begin
      bus.mem_resp_valid = 1'b0;
      for (int k = 1; k <= TMO; k++) begin
        bus.mem_req_ready = ((k - 1) == rDelay);
        #2;
        if (k < TMO) checkQuiet("watch", (k - 1) <= rDelay);
        else         checkResp("timeout", 32'hDEAD_BEEF, (k - 1) <= rDelay);
        nextCycle();
      end
      bus.mem_req_ready = 1'b0;
      errExp = 1'b1;
    end
  endtask

  task automatic resetInWait();
    ifuPend   = 1'b0;
    lsuPend   = 1'b1;
    lsuAddrV  = 32'h8000_0200;
    lsuWenV   = 1'b0;
    lsuWdataV = '0;
    lsuWmaskV = 4'b1111;
    doGrant();
    applyStimulus();
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    #2;
    checkQuiet("rstIssue", 1'b1);
    nextCycle();
    bus.mem_req_ready  = 1'b0;
    rst                = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hCAFE_0001;
    #2;
    checkOutput("rstWait.lsuResp", bus.lsu_resp_valid, 0);
    checkOutput("rstWait.ifuResp", bus.ifu_resp_valid, 0);
    checkOutput("rstWait.memValid", bus.mem_req_valid, 0);
    nextCycle();
    rst       = 1'b0;
    favourLsu = 1'b1;
    errExp    = 1'b0;
    #2;
    checkQuiet("stray", 1'b0);
    checkOutput("stray.memAddr", bus.mem_addr, 0);
    checkOutput("stray.lsuRdata", bus.lsu_rdata, 0);
    nextCycle();
    bus.mem_resp_valid = 1'b0;
  endtask

  initial begin
`ifdef MEM_ARB_RR_EN
    rrMode = 1'b1;
`endif
    rst                = 1'b1;
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = 32'h1234_0000;
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_addr       = 32'h5678_0000;
    bus.lsu_wen        = 1'b1;
    bus.lsu_wdata      = 32'hFFFF_FFFF;
    bus.lsu_wmask      = 4'b1111;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hAAAA_5555;
    nextCycle();
    nextCycle();
    #2;
    checkOutput("reset.ifuReady", bus.ifu_req_ready, 0);
    checkOutput("reset.lsuReady", bus.lsu_req_ready, 0);
    checkOutput("reset.ifuResp", bus.ifu_resp_valid, 0);
    checkOutput("reset.lsuResp", bus.lsu_resp_valid, 0);
    checkOutput("reset.ifuRdata", bus.ifu_rdata, 0);
    checkOutput("reset.lsuRdata", bus.lsu_rdata, 0);
    checkOutput("reset.memValid", bus.mem_req_valid, 0);
    checkOutput("reset.memAddr", bus.mem_addr, 0);
    checkOutput("reset.memWen", bus.mem_wen, 0);
    checkOutput("reset.memWmask", bus.mem_wmask, 0);
    checkOutput("reset.err", errTimeout, 0);
    nextCycle();
    rst = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    emptyIdle();

    // Single fetch with an immediate memory.
    ifuPend  = 1'b1;
    ifuAddrV = 32'h8000_0000;
    runTxn(0, 0, 1'b0, 32'h0000_0413);

    // Two back-to-back conflicts.
    ifuPend   = 1'b1;
    ifuAddrV  = 32'h8000_0004;
    lsuPend   = 1'b1;
    lsuAddrV  = 32'h8000_0300;
    lsuWenV   = 1'b0;
    lsuWmaskV = 4'b1111;
    runTxn(0, 0, 1'b0, 32'h1111_2222);
    lsuPend   = 1'b1;
    lsuAddrV  = 32'h8000_0304;
    runTxn(0, 1, 1'b0, 32'h3333_4444);
    runTxn(1, 0, 1'b0, 32'h5555_6666);

    // Store stalled three cycles by the memory.
    lsuPend   = 1'b1;
    lsuAddrV  = 32'h8000_0100;
    lsuWenV   = 1'b1;
    lsuWdataV = 32'h1234_5678;
    lsuWmaskV = 4'b0011;
    runTxn(3, 0, 1'b0, 32'h9999_8888);

    // Load that the memory accepts but never answers.
    lsuPend  = 1'b1;
    lsuAddrV = 32'h8000_0400;
    lsuWenV  = 1'b0;
    runTxn(1, 0, 1'b1, '0);

    // Back-to-back fetches with a one-cycle memory.
    for (int i = 0; i < 3; i++) begin
      ifuPend  = 1'b1;
      ifuAddrV = 32'h8000_1000 + 32'(4 * i);
      runTxn(0, 0, 1'b0, $urandom);
    end

    postNew = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int rd;
      if (!ifuPend && !lsuPend) begin
        emptyIdle();
        randomRequests(1'b1);
      end
      if ($urandom_range(0, 7) == 0) begin
        rd = $urandom_range(0, 7);
        runTxn((rd == 7) ? 99 : rd, 0, 1'b1, '0);
      end else begin
        runTxn($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, $urandom);
      end
    end

    postNew = 1'b0;
    resetInWait();
    ifuPend  = 1'b1;
    ifuAddrV = 32'h8000_2000;
    runTxn(0, 0, 1'b0, 32'h0BAD_F00D);

    postNew = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (!ifuPend && !lsuPend) randomRequests(1'b1);
      runTxn($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
